// File: rtl/viterbi_acs_ctrl.sv
// viterbi_acs_ctrl
//   Step sequencer for the 4-state (K=3) ACS_mem array of the Viterbi decoder.
//   Accepts 2-bit received symbols, clears the array at each frame start,
//   clocks the array one trellis step per symbol, picks the minimum-metric
//   state and streams decoded bits from that state's survivor register,
//   finishing each frame with a flush of the remaining survivor bits.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        symbol handshake; in_sym symbol, in_last frame end
//   acs_clr_n                registered active-low clear to the array
//   acs_ce                   clock-enable to the array ICG
//   acs_sym                  symbol broadcast to all four array cells
//   pm0..pm3                 array path metrics, state 0..3
//   surv0..surv3             array survivor words, bit0 = newest decision
//   out_valid/out_ready      decoded bit handshake; out_bit data, out_last end
//   best_state               state selected at the most recent EVAL
//   pm_hi                    sticky: min metric reached PM_HI_THR this frame
//   busy                     frame in progress
module viterbi_acs_ctrl #(
   parameter int unsigned ACS_LAT   = 2,
   parameter int unsigned PM_HI_THR = 96
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_sym,
   input  logic       in_last,
   output logic       acs_clr_n,
   output logic       acs_ce,
   output logic [1:0] acs_sym,
   input  logic [6:0] pm0,
   input  logic [6:0] pm1,
   input  logic [6:0] pm2,
   input  logic [6:0] pm3,
   input  logic [7:0] surv0,
   input  logic [7:0] surv1,
   input  logic [7:0] surv2,
   input  logic [7:0] surv3,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_bit,
   output logic       out_last,
   output logic [1:0] best_state,
   output logic       pm_hi,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT,
      S_STEP,
      S_EVAL,
      S_FLUSH
   } state_t;

   localparam logic [7:0] LAT_LAST = 8'(ACS_LAT - 1);
   localparam logic [6:0] HI_THR   = 7'(PM_HI_THR);

   state_t      state, state_nx;
   logic [7:0]  lat_cnt;
   logic [3:0]  step_cnt;
   logic [15:0] n_cnt;
   logic        last_r;
   logic [7:0]  fl_word;
   logic [2:0]  fl_cnt;

   logic        pend;
   logic        accept;
   logic [1:0]  best;
   logic [6:0]  min_pm;
   logic [7:0]  best_surv;
   logic [3:0]  step_inc;

   // A bit is still owed downstream; nothing new may be produced or accepted.
   assign pend     = out_valid && !out_ready;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != S_IDLE);
   assign step_inc = (step_cnt == 4'd8) ? 4'd8 : step_cnt + 4'd1;

   // Minimum search with strict compares so ties resolve to the lowest index.
   always_comb begin
      best   = 2'd0;
      min_pm = pm0;
      if (pm1 < min_pm) begin best = 2'd1; min_pm = pm1; end
      if (pm2 < min_pm) begin best = 2'd2; min_pm = pm2; end
      if (pm3 < min_pm) begin best = 2'd3; min_pm = pm3; end
      case (best)
         2'd0:    best_surv = surv0;
         2'd1:    best_surv = surv1;
         2'd2:    best_surv = surv2;
         default: best_surv = surv3;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         S_IDLE:  if (in_valid) state_nx = S_CLEAR;
         S_CLEAR: state_nx = S_WAIT;
         S_WAIT: begin
            in_ready = !pend;
            if (in_valid && !pend) state_nx = S_STEP;
         end
         S_STEP:  if (lat_cnt == LAT_LAST) state_nx = S_EVAL;
         S_EVAL:  if (!pend) state_nx = last_r ? S_FLUSH : S_WAIT;
         // fl_cnt reaches 0 once the final bit is loaded; leave when it is taken.
         S_FLUSH: if (fl_cnt == 3'd0 && !pend) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acs_clr_n  <= 1'b1;
         acs_ce     <= 1'b0;
         acs_sym    <= '0;
         lat_cnt    <= '0;
         step_cnt   <= '0;
         n_cnt      <= '0;
         last_r     <= 1'b0;
         fl_word    <= '0;
         fl_cnt     <= '0;
         out_valid  <= 1'b0;
         out_bit    <= 1'b0;
         out_last   <= 1'b0;
         best_state <= '0;
         pm_hi      <= 1'b0;
      end else begin
         // Registered from the next state so both strobes line up with the state.
         acs_clr_n <= (state_nx != S_CLEAR);
         acs_ce    <= (state_nx == S_STEP);

         // Handshake retires the current bit; an emission below overrides this.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            S_CLEAR: begin
               step_cnt <= '0;
               n_cnt    <= '0;
               pm_hi    <= 1'b0;
            end
            S_WAIT: begin
               if (accept) begin
                  acs_sym <= in_sym;
                  last_r  <= in_last;
                  lat_cnt <= '0;
                  if (n_cnt != '1) n_cnt <= n_cnt + 16'd1;
               end
            end
            S_STEP: lat_cnt <= lat_cnt + 8'd1;
            S_EVAL: begin
               if (!pend) begin
                  best_state <= best;
                  pm_hi      <= pm_hi | (min_pm >= HI_THR);
                  step_cnt   <= step_inc;
                  if (step_inc == 4'd8) begin
                     out_valid <= 1'b1;
                     out_bit   <= best_surv[7];
                     out_last  <= 1'b0;
                  end
                  if (last_r) begin
                     fl_word <= best_surv;
                     fl_cnt  <= (n_cnt >= 16'd7) ? 3'd7 : n_cnt[2:0];
                  end
               end
            end
            S_FLUSH: begin
               if (!pend && fl_cnt != 3'd0) begin
                  out_valid <= 1'b1;
                  out_bit   <= fl_word[fl_cnt - 3'd1];
                  out_last  <= (fl_cnt == 3'd1);
                  fl_cnt    <= fl_cnt - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// tb_viterbi_acs_ctrl
//   Self-checking bench for viterbi_acs_ctrl. A behavioural stand-in for the
//   ACS array presents per-step metrics/survivors from tables; a frame-level
//   reference computes the expected decoded bit stream from those tables.
module tb_viterbi_acs_ctrl;

   localparam int unsigned ACS_LAT   = 2;
   localparam int unsigned PM_HI_THR = 96;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_sym;
   logic       in_last;
   logic       acs_clr_n;
   logic       acs_ce;
   logic [1:0] acs_sym;
   logic [6:0] pm0, pm1, pm2, pm3;
   logic [7:0] surv0, surv1, surv2, surv3;
   logic       out_valid;
   logic       out_ready;
   logic       out_bit;
   logic       out_last;
   logic [1:0] best_state;
   logic       pm_hi;
   logic       busy;

   always #5 clk = ~clk;

   viterbi_acs_ctrl #(.ACS_LAT(ACS_LAT), .PM_HI_THR(PM_HI_THR)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
      .acs_clr_n(acs_clr_n), .acs_ce(acs_ce), .acs_sym(acs_sym),
      .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
      .surv0(surv0), .surv1(surv1), .surv2(surv2), .surv3(surv3),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
      .best_state(best_state), .pm_hi(pm_hi), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] pm_tab [64][4];
   logic [7:0] sv_tab [64][4];

   int unsigned app_idx    = 0;
   int unsigned ce_in_step = 0;
   int unsigned ce_total   = 0;
   int unsigned clr_cnt    = 0;
   bit          got_bits[$];
   bit          got_last[$];
   bit          exp_bits[$];
   bit          exp_last[$];
   logic [1:0]  exp_best;
   bit          exp_hi;
   logic        prev_pend = 1'b0, prev_bit = 1'b0, prev_last = 1'b0, prev_clr_low = 1'b0;
   logic [1:0]  cur_sym = '0;
   bit          bp_arm = 1'b0;
   bit          bp_used;
   int          hold_left;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},   in_ready,   0);
      chk({tag, "_acs_clr_n"},  acs_clr_n,  1);
      chk({tag, "_acs_ce"},     acs_ce,     0);
      chk({tag, "_acs_sym"},    acs_sym,    0);
      chk({tag, "_out_valid"},  out_valid,  0);
      chk({tag, "_out_bit"},    out_bit,    0);
      chk({tag, "_out_last"},   out_last,   0);
      chk({tag, "_best_state"}, best_state, 0);
      chk({tag, "_pm_hi"},      pm_hi,      0);
      chk({tag, "_busy"},       busy,       0);
   endtask

   // Array stand-in plus bus monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (!rst) begin
         ce_in_step   = 0;
         prev_pend    = 1'b0;
         prev_clr_low = 1'b0;
         pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0;
         surv0 = '0; surv1 = '0; surv2 = '0; surv3 = '0;
      end else begin
         if (prev_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_bit",   out_bit,   prev_bit);
            chk("hold_last",  out_last,  prev_last);
         end
         if (out_valid && !out_ready) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_acs_ce",   acs_ce,   0);
         end
         prev_pend = out_valid && !out_ready;
         prev_bit  = out_bit;
         prev_last = out_last;
         if (out_valid && out_ready) begin
            got_bits.push_back(out_bit);
            got_last.push_back(out_last);
         end
         if (prev_clr_low) begin
            chk("clr_width", acs_clr_n, 1);
            chk("pm_hi_clr", pm_hi, 0);
         end
         if (!acs_clr_n) begin
            clr_cnt++;
            app_idx    = 0;
            ce_in_step = 0;
         end
         prev_clr_low = !acs_clr_n;
         if (acs_ce) begin
            chk("acs_sym_hold", acs_sym, cur_sym);
            ce_total++;
            ce_in_step++;
            if (ce_in_step == ACS_LAT) begin
               ce_in_step = 0;
               if (app_idx < 64) begin
                  pm0 = pm_tab[app_idx][0]; pm1 = pm_tab[app_idx][1];
                  pm2 = pm_tab[app_idx][2]; pm3 = pm_tab[app_idx][3];
                  surv0 = sv_tab[app_idx][0]; surv1 = sv_tab[app_idx][1];
                  surv2 = sv_tab[app_idx][2]; surv3 = sv_tab[app_idx][3];
               end
               app_idx++;
            end
         end
      end
   end

   // Downstream: random readiness, with one forced 5-cycle stall when armed.
   initial begin
      out_ready = 1'b1;
      hold_left = 0;
      bp_used   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (hold_left == 0 && bp_arm && !bp_used && out_valid) begin
            hold_left = 5;
            bp_used   = 1'b1;
         end
         if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
         end else begin
            out_ready = ($urandom_range(3) != 0);
         end
      end
   end

   // Frame reference: bits from step 8 onward are the MSB of the winning
   // survivor; the final winner's survivor supplies the last min(N,7) bits.
   task automatic model(input int n);
      int         best;
      logic [7:0] w;
      int         nf;
      exp_bits.delete();
      exp_last.delete();
      exp_hi = 1'b0;
      best   = 0;
      for (int k = 0; k < n; k++) begin
         best = 0;
         for (int s = 1; s < 4; s++) if (pm_tab[k][s] < pm_tab[k][best]) best = s;
         if (int'(pm_tab[k][best]) >= int'(PM_HI_THR)) exp_hi = 1'b1;
         if (k >= 7) begin
            w = sv_tab[k][best];
            exp_bits.push_back(w[7]);
            exp_last.push_back(1'b0);
         end
      end
      w  = sv_tab[n-1][best];
      nf = (n < 7) ? n : 7;
      for (int i = nf - 1; i >= 0; i--) begin
         exp_bits.push_back(w[i]);
         exp_last.push_back(i == 0);
      end
      exp_best = 2'(best);
   endtask

   task automatic fill_rand(input int n, input int pm_max);
      for (int k = 0; k < n; k++)
         for (int s = 0; s < 4; s++) begin
            pm_tab[k][s] = 7'($urandom_range(pm_max));
            sv_tab[k][s] = 8'($urandom);
         end
   endtask

   // Called at posedge+1; returns at posedge+1.
   task automatic run_frame(input int n, input int abort_at);
      int base_got, base_ce, base_clr, nl;
      bit acc, done;
      base_got = got_bits.size();
      base_ce  = ce_total;
      base_clr = clr_cnt;
      model(n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(2)) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_sym   = 2'($urandom_range(3));
         in_last  = (k == n - 1);
         acc = 1'b0;
         for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
         chk($sformatf("accept_%0d", k), acc, 1);
         if (!acc) return;
         cur_sym = in_sym;
      end
      if (abort_at > 0) begin
         for (int t = 0; t < 3000 && (got_bits.size() - base_got) < abort_at; t++) @(negedge clk);
         chk("abort_reach", (got_bits.size() - base_got) >= abort_at, 1);
         @(posedge clk); #2;
         rst = 1'b0;
         #1;
         chk_reset_vals("abort");
         nl = 0;
         for (int i = base_got; i < got_last.size(); i++) if (got_last[i]) nl++;
         chk("abort_no_last", nl, 0);
         repeat (3) @(negedge clk);
         rst = 1'b1;
         @(posedge clk); #1;
         return;
      end
      done = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
         @(negedge clk);
         done = !busy;
      end
      chk("frame_done", done, 1);
      chk("bit_count", got_bits.size() - base_got, exp_bits.size());
      for (int i = 0; i < exp_bits.size() && base_got + i < got_bits.size(); i++) begin
         chk($sformatf("bit_%0d", i),  got_bits[base_got + i], exp_bits[i]);
         chk($sformatf("last_%0d", i), got_last[base_got + i], exp_last[i]);
      end
      chk("ce_count",   ce_total - base_ce, ACS_LAT * n);
      chk("clr_pulses", clr_cnt - base_clr, 1);
      chk("best_state", best_state, exp_best);
      chk("pm_hi",      pm_hi, exp_hi);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b0; in_valid = 1'b0; in_sym = '0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // All-zero frame with an ideal array: all metrics/survivors zero.
      for (int k = 0; k < 10; k++)
         for (int s = 0; s < 4; s++) begin pm_tab[k][s] = '0; sv_tab[k][s] = '0; end
      run_frame(10, 0);

      // Tie-break at step 8: states 1 and 2 tie, state 1 wins.
      fill_rand(8, 90);
      pm_tab[7] = '{7'd5, 7'd3, 7'd3, 7'd9};
      sv_tab[7][1] = 8'hA5;
      base = got_bits.size();
      run_frame(8, 0);
      chk("tie_best", best_state, 1);
      if (got_bits.size() > base) chk("tie_bit", got_bits[base], 1);

      // Short frame: winner's survivor 00000101 gives 1,0,1.
      fill_rand(3, 90);
      pm_tab[2] = '{7'd0, 7'd20, 7'd20, 7'd20};
      sv_tab[2][0] = 8'b0000_0101;
      run_frame(3, 0);

      // Metric level: min 100 at one step sets sticky pm_hi.
      fill_rand(5, 90);
      pm_tab[2] = '{7'd110, 7'd100, 7'd120, 7'd127};
      run_frame(5, 0);
      chk("pm_hi_set", pm_hi, 1);

      // Single-symbol frame; pm_hi must clear at its CLEAR.
      fill_rand(1, 90);
      run_frame(1, 0);

      // Forced 5-cycle downstream stall.
      bp_arm = 1'b1;
      fill_rand(12, 127);
      run_frame(12, 0);
      bp_arm = 1'b0;
      chk("bp_used", bp_used, 1);

      // Reset after 2 of 7 flush bits, then a full frame.
      fill_rand(12, 127);
      run_frame(12, 7);
      fill_rand(9, 127);
      run_frame(9, 0);

      repeat (8) begin
         int n;
         n = $urandom_range(20, 1);
         fill_rand(n, 127);
         run_frame(n, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
